sort_share_ctrl: RTL and testbench
==================================

Name: sort_share_ctrl

Overview:
- Shares one sort_N network instance (combinational or pipelined) among NUM_REQ requesters. Each requester sends a vector of N words.
- The block arbitrates round-robin, registers the granted vector onto the sorter inputs, and tracks in-flight jobs by requester ID. Results are captured into a response FIFO and returned over a valid/ready interface.
- A credit scheme guarantees every in-flight result has a FIFO slot, so the sorter never needs to stall.
- Results are checked for ascending order on capture.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- N, 10, words per sort job
- W, 32, word width (unsigned)
- LATENCY, 0, register stages inside the attached sorter (0 = combinational)
- RESP_DEPTH, 4, response FIFO entries (must be >= LATENCY+1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester job valid
- req_data  in  NUM_REQ*N*W  job vectors; requester r, word k at bits [(r*N+k)*W +: W]
- req_ready  out  NUM_REQ  one-hot accept
- srt_in  out  N*W  registered vector to sorter data_0..data_N-1 (word k at [k*W +: W])
- srt_out  in  N*W  sorter sort_0..sort_N-1
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  $clog2(NUM_REQ)  originating requester
- resp_data  out  N*W  sorted vector
- busy  out  1  any job in flight or queued
- err_unsorted  out  1  sticky: a captured result was not non-decreasing

Behaviour:
- Reset (async assert, sync release): srt_in=0, all FIFO/in-flight state cleared, resp_valid=0, resp_id=0, resp_data=0, busy=0, err_unsorted=0, round-robin pointer=0. Reset mid-operation drops all in-flight and queued jobs; no response is emitted for them.
- Credits: occ = inflight_cnt + fifo_cnt, computed from registered values. can_issue = (occ < RESP_DEPTH). A pop in cycle t frees its credit from cycle t+1 (no same-cycle bypass).
- Arbitration: when can_issue=1, grant the first r with req_valid[r]=1, searching from ptr upward with wrap. req_ready = grant & can_issue (combinational, at most one bit set). req_ready is 0 for all requesters when can_issue=0.
- Pointer update: on accept of r, ptr <= (r+1) mod NUM_REQ. ptr holds otherwise.
- Requesters hold req_valid/req_data stable until accepted. req_ready does not depend on resp_ready.
- Issue: on the accepting edge E0, srt_in <= req_data slice of r. A valid/ID token enters a LATENCY-deep shift pipe; inflight_cnt increments.
- srt_in holds its value when no accept occurs. Sorter output is not captured for non-token cycles.
- Capture: at edge E0+1+LATENCY, srt_out and the ID are written to the FIFO tail and inflight_cnt decrements. resp_valid rises after that edge if the FIFO was empty.
- With back-to-back issues, the throughput is 1 job/cycle while credits last.
- Sortedness check at capture: if any word k has srt_out[k] > srt_out[k+1] (unsigned), set err_unsorted. It is cleared only by reset. The data is still enqueued.
- Output: resp_id and resp_data show the FIFO head. A pop occurs on resp_valid & resp_ready. The FIFO is first-in first-out, preserving issue order.
- Simultaneous capture and pop are allowed, including with a full FIFO (the credit scheme makes overflow impossible). Push to an empty FIFO is visible the next cycle, with no bypass.
- busy = (inflight_cnt != 0) | (fifo_cnt != 0).
- Counters: inflight_cnt width $clog2(LATENCY+2), fifo_cnt width $clog2(RESP_DEPTH+1). Pointers wrap modulo RESP_DEPTH.

Test Plan:
- Single job, LATENCY=0: req_valid=4'b0100 with vector {9,8,7,6,5,4,3,2,1,0} → req_ready=4'b0100 at E0; resp_valid high after E0+1; resp_id=2; data 0..9 ascending; busy falls after the pop.
- Fairness: all four req_valid held high, resp_ready=1 → accept order 0,1,2,3,0,... with one grant per cycle; each resp_id matches its grant order.
- Backpressure, RESP_DEPTH=4, resp_ready=0, all requesters valid → exactly 4 accepts, then req_ready=0. Raising resp_ready for one cycle pops 1; exactly one new accept follows on the next cycle.
- LATENCY=3 with a pipelined sorter model: 3 back-to-back jobs → responses appear at E0+4, E0+5, E0+6 in issue order with correct IDs.
- Error flag: a sorter model that swaps words 3/4 on the output → err_unsorted=1 after capture, data still delivered; it stays 1 until rst_n=0.
- Reset mid-flight: issue 2 jobs, pull rst_n low before capture → outputs zero immediately. After release, no stale response appears and ptr=0 (requester 0 is granted first).

Source files
------------

// File: rtl/sort_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sort_share_ctrl
// Brief    : Round-robin sharing of one sort_N network among NUM_REQ
//            requesters, with credit-protected response FIFO.
// Revision : 1.0
// ============================================================================
module sort_share_ctrl #(
    parameter int NUM_REQ    = 4,
    parameter int N          = 10,
    parameter int W          = 32,
    parameter int LATENCY    = 0,
    parameter int RESP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*N*W-1:0]     req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [N*W-1:0]             srt_in,
    input  logic [N*W-1:0]             srt_out,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [N*W-1:0]             resp_data,
    output logic                       busy,
    output logic                       err_unsorted
);

    localparam int c_ID_W  = $clog2(NUM_REQ);
    localparam int c_IF_W  = $clog2(LATENCY + 2);
    localparam int c_FC_W  = $clog2(RESP_DEPTH + 1);
    localparam int c_PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    logic [c_ID_W-1:0]  r_ptr;
    logic [c_IF_W-1:0]  r_inflight_cnt;
    logic [c_FC_W-1:0]  r_fifo_cnt;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [LATENCY:0]   r_tok_v;
    logic [c_ID_W-1:0]  r_tok_id [LATENCY+1];
    logic [N*W-1:0]     r_mem_data [RESP_DEPTH];
    logic [c_ID_W-1:0]  r_mem_id [RESP_DEPTH];
    logic               r_err;

    int                 w_occ;
    logic               w_can_issue;
    logic               w_gnt_any;
    logic [c_ID_W-1:0]  w_gnt_idx;
    logic               w_accept;
    logic               w_cap;
    logic [c_ID_W-1:0]  w_cap_id;
    logic               w_pop;
    logic [N-2:0]       w_desc;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(RESP_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // Every job in the sorter or the FIFO holds one credit, so a capture
    // always finds a free FIFO slot and the sorter never stalls.
    assign w_occ       = int'(r_inflight_cnt) + int'(r_fifo_cnt);
    assign w_can_issue = (w_occ < RESP_DEPTH);

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_gnt_any && req_valid[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = c_ID_W'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign w_accept  = w_gnt_any & w_can_issue;
    assign req_ready = w_accept ? (NUM_REQ'(1) << w_gnt_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            srt_in <= '0;
        end else if (w_accept) begin
            r_ptr  <= (w_gnt_idx == c_ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + c_ID_W'(1);
            srt_in <= req_data[int'(w_gnt_idx)*N*W +: N*W];
        end
    end

    // Token pipe runs alongside the sorter: stage 0 marks srt_in as fresh,
    // stage LATENCY marks srt_out as the matching result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tok_v <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                r_tok_id[i] <= '0;
            end
        end else begin
            r_tok_v[0]  <= w_accept;
            r_tok_id[0] <= w_gnt_idx;
            for (int i = 1; i <= LATENCY; i++) begin
                r_tok_v[i]  <= r_tok_v[i-1];
                r_tok_id[i] <= r_tok_id[i-1];
            end
        end
    end

    assign w_cap    = r_tok_v[LATENCY];
    assign w_cap_id = r_tok_id[LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight_cnt <= '0;
        end else begin
            r_inflight_cnt <= r_inflight_cnt + c_IF_W'(w_accept) - c_IF_W'(w_cap);
        end
    end

    generate
        for (genvar k = 0; k < N - 1; k++) begin : g_order_chk
            assign w_desc[k] = (srt_out[k*W +: W] > srt_out[(k+1)*W +: W]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_cap && (|w_desc)) begin
            r_err <= 1'b1;
        end
    end

    assign w_pop = resp_valid & resp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_id[i]   <= '0;
            end
        end else begin
            if (w_cap) begin
                r_mem_data[r_wr_ptr] <= srt_out;
                r_mem_id[r_wr_ptr]   <= w_cap_id;
                r_wr_ptr             <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            r_fifo_cnt <= r_fifo_cnt + c_FC_W'(w_cap) - c_FC_W'(w_pop);
        end
    end

    assign resp_valid   = (r_fifo_cnt != '0);
    assign resp_id      = r_mem_id[r_rd_ptr];
    assign resp_data    = r_mem_data[r_rd_ptr];
    assign busy         = (r_inflight_cnt != '0) | (r_fifo_cnt != '0);
    assign err_unsorted = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sort_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_share_ctrl
// Brief    : Scoreboard bench with a pipelined sorter model (LATENCY=3).
// Revision : 1.0
// ============================================================================
module tb_sort_share_ctrl;

    localparam int NUM_REQ = 4;
    localparam int N       = 10;
    localparam int W       = 32;
    localparam int LAT     = 3;
    localparam int DEPTH   = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*N*W-1:0] req_data;
    logic [NUM_REQ-1:0]     req_ready;
    logic [N*W-1:0]         srt_in;
    logic [N*W-1:0]         srt_out;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [1:0]             resp_id;
    logic [N*W-1:0]         resp_data;
    logic                   busy;
    logic                   err_unsorted;

    int  total = 0;
    int  bad   = 0;
    bit  inject = 1'b0;
    longint cyc = 0;

    sort_share_ctrl #(
        .NUM_REQ(NUM_REQ), .N(N), .W(W), .LATENCY(LAT), .RESP_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .srt_in(srt_in), .srt_out(srt_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .busy(busy), .err_unsorted(err_unsorted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ascending sort of a packed vector; optional swap of words 3/4 models a faulty sorter.
    function automatic logic [N*W-1:0] sort_vec(input logic [N*W-1:0] v, input bit sw);
        logic [W-1:0]   a [N];
        logic [W-1:0]   t;
        logic [N*W-1:0] o;
        for (int k = 0; k < N; k++) a[k] = v[k*W +: W];
        for (int i = 0; i < N - 1; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        if (sw) begin t = a[3]; a[3] = a[4]; a[4] = t; end
        for (int k = 0; k < N; k++) o[k*W +: W] = a[k];
        return o;
    endfunction

    logic [N*W-1:0] sorted_now;
    logic [N*W-1:0] spipe [LAT];
    always_comb sorted_now = sort_vec(srt_in, inject);
    always @(posedge clk) begin
        spipe[0] <= sorted_now;
        for (int i = 1; i < LAT; i++) spipe[i] <= spipe[i-1];
    end
    assign srt_out = spipe[LAT-1];

    task automatic chk(input string name, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct {
        int             id;
        logic [N*W-1:0] data;
        longint         rdy;
    } exp_t;

    exp_t   q[$];
    int     outstanding = 0;
    int     mptr = 0;
    longint err_at = -1;

    // Monitor: job-level model of arbitration, credits, latency and ordering.
    always @(negedge clk) begin : p_mon
        logic [NUM_REQ-1:0] exp_ready;
        int                 g;
        bit                 exp_rv;
        exp_t               e;
        if (!rst_n) begin
            q.delete();
            outstanding = 0;
            mptr        = 0;
            err_at      = -1;
        end else begin
            exp_ready = '0;
            g         = -1;
            if (outstanding < DEPTH) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (g < 0 && req_valid[(mptr + i) % NUM_REQ]) g = (mptr + i) % NUM_REQ;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            exp_rv = (q.size() > 0) && (q[0].rdy <= cyc);
            chk("req_ready", req_ready, exp_ready);
            chk("busy", busy, outstanding != 0);
            chk("resp_valid", resp_valid, exp_rv);
            chk("err_unsorted", err_unsorted, (err_at >= 0) && (cyc >= err_at));
            if (exp_rv && resp_ready) begin
                chk("resp_id", resp_id, q[0].id);
                chk("resp_data", resp_data, q[0].data);
                void'(q.pop_front());
                outstanding--;
            end
            if (g >= 0) begin
                e.id   = g;
                e.data = sort_vec(req_data[g*N*W +: N*W], inject);
                e.rdy  = cyc + 2 + LAT;
                for (int k = 0; k < N - 1; k++)
                    if (e.data[k*W +: W] > e.data[(k+1)*W +: W] && err_at < 0) err_at = e.rdy;
                q.push_back(e);
                outstanding++;
                mptr = (g + 1) % NUM_REQ;
            end
        end
    end

    int left [NUM_REQ];
    int acc_cnt = 0;

    task automatic new_data(input int r);
        logic [W-1:0] val;
        for (int k = 0; k < N; k++) begin
            val = ($urandom_range(1) == 1) ? W'($urandom) : W'($urandom_range(7));
            req_data[(r*N+k)*W +: W] = val;
        end
    endtask

    task automatic start(input logic [NUM_REQ-1:0] mask, input int jobs);
        for (int r = 0; r < NUM_REQ; r++) begin
            if (mask[r]) begin
                left[r] = jobs;
                new_data(r);
                req_valid[r] = 1'b1;
            end
        end
    endtask

    task automatic step(input int rr_pct);
        logic [NUM_REQ-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (acc[r]) begin
                acc_cnt++;
                left[r]--;
                if (left[r] > 0) new_data(r);
                else req_valid[r] = 1'b0;
            end
        end
        resp_ready = (rr_pct >= 100) ? 1'b1 : ($urandom_range(99) < rr_pct);
    endtask

    task automatic drain(input int maxc);
        int c = 0;
        resp_ready = 1'b1;
        while (c < maxc && (busy || req_valid != '0)) begin
            step(100);
            c++;
        end
        total++;
        if (busy || req_valid != '0) begin
            bad++;
            $display("FAIL drain_timeout: busy=%0b req_valid=%0b expected idle", busy, req_valid);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) left[r] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_unsorted, 0);
        chk("rst_srt_in", srt_in, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single job from requester 2, descending input.
        for (int k = 0; k < N; k++) req_data[(2*N+k)*W +: W] = W'(9 - k);
        left[2]      = 1;
        req_valid[2] = 1'b1;
        resp_ready   = 1'b1;
        base = acc_cnt;
        step(100);
        chk("single_accept", acc_cnt - base, 1);
        drain(50);

        // Fairness: all requesters, one grant per cycle while credits last.
        start('1, 3);
        base = acc_cnt;
        repeat (4) step(100);
        chk("fair_b2b_accepts", acc_cnt - base, 4);
        drain(300);

        // Backpressure: credits run out at DEPTH, a single pop frees one.
        resp_ready = 1'b0;
        start('1, 3);
        base = acc_cnt;
        repeat (11) step(0);
        chk("bp_accepts", acc_cnt - base, DEPTH);
        step(100);
        repeat (5) step(0);
        chk("bp_after_pop", acc_cnt - base, DEPTH + 1);
        drain(300);

        // Three back-to-back jobs through the pipelined sorter.
        start(4'b1011, 1);
        base = acc_cnt;
        repeat (3) step(100);
        chk("lat_b2b_accepts", acc_cnt - base, 3);
        drain(100);

        // Randomized traffic and consumer backpressure.
        for (int it = 0; it < 8; it++) begin
            int c = 0;
            start(NUM_REQ'($urandom_range(1, 15)), $urandom_range(1, 4));
            while (req_valid != '0 && c < 400) begin
                step(60);
                c++;
            end
            drain(200);
        end

        // Faulty sorter output sets the sticky error, data still delivered.
        inject = 1'b1;
        for (int k = 0; k < N; k++) req_data[(1*N+k)*W +: W] = W'((k * 3) % 10);
        left[1]      = 1;
        req_valid[1] = 1'b1;
        drain(100);
        chk("err_set", err_unsorted, 1);
        inject = 1'b0;
        start(4'b1000, 2);
        drain(100);
        chk("err_sticky", err_unsorted, 1);

        // Reset with two jobs in flight.
        start(4'b0110, 1);
        base = acc_cnt;
        repeat (2) step(100);
        chk("rst_mid_accepts", acc_cnt - base, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_srt_in", srt_in, 0);
        chk("mid_rst_resp_data", resp_data, 0);
        chk("mid_rst_err", err_unsorted, 0);
        req_valid = '0;
        for (int r = 0; r < NUM_REQ; r++) left[r] = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start('1, 1);
        @(negedge clk);
        chk("post_rst_grant", req_ready, 4'b0001);
        drain(200);
        repeat (6) step(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
